// File: rtl/ex_stage_if.sv
// Bundle of the ID->EX inputs and EX->MEM registered outputs of the execute stage.
// The slave modport is the EX stage itself; the master side is the surrounding pipeline.
interface ex_stage_if;
  logic [3:0]  opcode_id_ex;
  logic [15:0] id_pc;
  logic [15:0] id_src1;
  logic [15:0] id_src2;
  logic [15:0] id_imm;
  logic [15:0] id_store_data;
  logic [2:0]  id_op_dest;
  logic        id_mem_write_en;
  logic        id_wb_mux;
  logic        id_wb_en;
  logic        mem_ready;

  logic [3:0]  opcode_ex_mem;
  logic [15:0] ex_alu_res;
  logic [15:0] ex_store_data;
  logic [2:0]  ex_op_dest;
  logic        ex_mem_write_en;
  logic        ex_wb_mux;
  logic        ex_wb_en;
  logic        ex_stall;
  logic        ex_branch_taken;
  logic [15:0] ex_branch_target;

  modport master (
    output opcode_id_ex, id_pc, id_src1, id_src2, id_imm, id_store_data,
           id_op_dest, id_mem_write_en, id_wb_mux, id_wb_en, mem_ready,
    input  opcode_ex_mem, ex_alu_res, ex_store_data, ex_op_dest,
           ex_mem_write_en, ex_wb_mux, ex_wb_en, ex_stall,
           ex_branch_taken, ex_branch_target
  );

  modport slave (
    input  opcode_id_ex, id_pc, id_src1, id_src2, id_imm, id_store_data,
           id_op_dest, id_mem_write_en, id_wb_mux, id_wb_en, mem_ready,
    output opcode_ex_mem, ex_alu_res, ex_store_data, ex_op_dest,
           ex_mem_write_en, ex_wb_mux, ex_wb_en, ex_stall,
           ex_branch_taken, ex_branch_target
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU, 16-cycle shift-add multiplier, BZ redirect,
// and the EX/MEM pipeline register that holds while mem_ready is low.
module ex_stage #(
  parameter logic [3:0] NOP  = 4'd0,
  parameter logic [3:0] ADD  = 4'd1,
  parameter logic [3:0] SUB  = 4'd2,
  parameter logic [3:0] AND  = 4'd3,
  parameter logic [3:0] OR   = 4'd4,
  parameter logic [3:0] XOR  = 4'd5,
  parameter logic [3:0] SLL  = 4'd6,
  parameter logic [3:0] SRL  = 4'd7,
  parameter logic [3:0] SRA  = 4'd8,
  parameter logic [3:0] ADDI = 4'd9,
  parameter logic [3:0] LD   = 4'd10,
  parameter logic [3:0] ST   = 4'd11,
  parameter logic [3:0] BZ   = 4'd12,
  parameter logic [3:0] MUL  = 4'd13
) (
  input logic      clk,
  input logic      rst,
  ex_stage_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] res;
    logic [15:0] sd;
    logic [2:0]  dest;
    logic        mw;
    logic        wbm;
    logic        wbe;
  } pipe_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [15:0] mcand;
  logic [15:0] mplier;
  logic [15:0] acc;
  pipe_t       mul_ctl;
  pipe_t       pipe_q;
  pipe_t       nrm;
  logic [15:0] alu_res;
  logic        stall;

  always_comb begin
    alu_res = 16'h0000;
    case (bus.opcode_id_ex)
      ADD:           alu_res = bus.id_src1 + bus.id_src2;
      SUB:           alu_res = bus.id_src1 - bus.id_src2;
      AND:           alu_res = bus.id_src1 & bus.id_src2;
      OR:            alu_res = bus.id_src1 | bus.id_src2;
      XOR:           alu_res = bus.id_src1 ^ bus.id_src2;
      SLL:           alu_res = bus.id_src1 << bus.id_src2[3:0];
      SRL:           alu_res = bus.id_src1 >> bus.id_src2[3:0];
      SRA:           alu_res = 16'($signed(bus.id_src1) >>> bus.id_src2[3:0]);
      ADDI, LD, ST:  alu_res = bus.id_src1 + bus.id_imm;
      NOP, BZ, MUL:  alu_res = 16'h0000;
      default:       alu_res = 16'h0000;
    endcase
  end

  // Single-cycle load value; BZ never writes back or stores, 14-15 become bubbles
  always_comb begin
    nrm.op   = bus.opcode_id_ex;
    nrm.res  = alu_res;
    nrm.sd   = bus.id_store_data;
    nrm.dest = bus.id_op_dest;
    nrm.mw   = bus.id_mem_write_en;
    nrm.wbm  = bus.id_wb_mux;
    nrm.wbe  = bus.id_wb_en;
    if (bus.opcode_id_ex == BZ) begin
      nrm.mw  = 1'b0;
      nrm.wbe = 1'b0;
    end
    if (bus.opcode_id_ex > MUL) nrm = '0;
  end

  assign stall = !bus.mem_ready
              || (state == IDLE && bus.opcode_id_ex == MUL)
              || (state == BUSY);

  assign bus.ex_stall         = stall;
  assign bus.ex_branch_taken  = (bus.opcode_id_ex == BZ) && (bus.id_src1 == 16'h0000)
                              && (state == IDLE) && !stall;
  assign bus.ex_branch_target = bus.id_pc + bus.id_imm;

  assign bus.opcode_ex_mem   = pipe_q.op;
  assign bus.ex_alu_res      = pipe_q.res;
  assign bus.ex_store_data   = pipe_q.sd;
  assign bus.ex_op_dest      = pipe_q.dest;
  assign bus.ex_mem_write_en = pipe_q.mw;
  assign bus.ex_wb_mux       = pipe_q.wbm;
  assign bus.ex_wb_en        = pipe_q.wbe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      mcand   <= 16'h0000;
      mplier  <= 16'h0000;
      acc     <= 16'h0000;
      mul_ctl <= '0;
      pipe_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.mem_ready) begin
            if (bus.opcode_id_ex == MUL) begin
              state   <= BUSY;
              cnt     <= 4'd0;
              mcand   <= bus.id_src1;
              mplier  <= bus.id_src2;
              acc     <= 16'h0000;
              mul_ctl <= nrm;
              pipe_q  <= '0;
            end else begin
              pipe_q <= nrm;
            end
          end
        end
        // One multiplier bit per cycle; the iteration ignores mem_ready
        BUSY: begin
          acc    <= acc + (mplier[0] ? mcand : 16'h0000);
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 4'd1;
          if (cnt == 4'd15) state <= DONE;
          if (bus.mem_ready) pipe_q <= '0;
        end
        DONE: begin
          if (bus.mem_ready) begin
            state      <= IDLE;
            pipe_q     <= mul_ctl;
            pipe_q.op  <= MUL;
            pipe_q.res <= acc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: stimulus pushes hand-computed EX/MEM register
// contents per accepting edge; a monitor pops and compares after every edge.
module tb_ex_stage;
  localparam logic [3:0] NOP = 4'd0, ADD = 4'd1, SUB = 4'd2, AND = 4'd3,
                         OR = 4'd4, XOR = 4'd5, SLL = 4'd6, SRL = 4'd7,
                         SRA = 4'd8, ADDI = 4'd9, LD = 4'd10, ST = 4'd11,
                         BZ = 4'd12, MUL = 4'd13;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;

  logic [41:0] exp_q[$];
  logic [41:0] last_exp = '0;
  logic [41:0] dut_vec;

  ex_stage_if bus();

  ex_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  assign dut_vec = {bus.opcode_ex_mem, bus.ex_alu_res, bus.ex_store_data, bus.ex_op_dest,
                    bus.ex_mem_write_en, bus.ex_wb_mux, bus.ex_wb_en};

  function automatic logic [41:0] pack(input logic [3:0] op, input logic [15:0] res,
                                       input logic [15:0] sd, input logic [2:0] dest,
                                       input logic mw, input logic wbm, input logic wbe);
    return {op, res, sd, dest, mw, wbm, wbe};
  endfunction

  task automatic check_output(input string name, input logic [47:0] act, input logic [47:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] op, input logic [15:0] pc,
                                input logic [15:0] s1, input logic [15:0] s2,
                                input logic [15:0] imm, input logic [15:0] sd,
                                input logic [2:0] dest, input logic mw, input logic wbm,
                                input logic wbe, input logic ready);
    bus.opcode_id_ex    = op;
    bus.id_pc           = pc;
    bus.id_src1         = s1;
    bus.id_src2         = s2;
    bus.id_imm          = imm;
    bus.id_store_data   = sd;
    bus.id_op_dest      = dest;
    bus.id_mem_write_en = mw;
    bus.id_wb_mux       = wbm;
    bus.id_wb_en        = wbe;
    bus.mem_ready       = ready;
  endtask

  // One single-cycle instruction accepted on the next edge
  task automatic single(input logic [3:0] op, input logic [15:0] s1, input logic [15:0] s2,
                        input logic [15:0] imm, input logic [15:0] sd, input logic [2:0] dest,
                        input logic mw, input logic wbm, input logic wbe,
                        input logic [41:0] exp_vec, input string name);
    @(negedge clk);
    apply_stimulus(op, 16'h0100, s1, s2, imm, sd, dest, mw, wbm, wbe, 1'b1);
    #1;
    check_output({name, "_stall"}, 48'(bus.ex_stall), 48'(1'b0));
    exp_q.push_back(exp_vec);
  endtask

  task automatic print_summary();
    $display("test done: total=%0d bad=%0d", total, bad);
  endtask

  // Monitor: accepted edges pop the scoreboard, held edges must keep the last value
  initial begin
    logic took;
    logic in_rst;
    logic [41:0] e;
    forever begin
      @(posedge clk);
      took   = !rst && bus.mem_ready;
      in_rst = rst;
      #1;
      if (in_rst || rst) begin
        last_exp = '0;
      end else if (took) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL sb_underflow: got %h expected none queued", dut_vec);
        end else begin
          e = exp_q.pop_front();
          last_exp = e;
          check_output("pipe", 48'(dut_vec), 48'(e));
        end
      end else begin
        check_output("hold", 48'(dut_vec), 48'(last_exp));
      end
    end
  end

  initial begin
    #100000;
    total++;
    bad++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    print_summary();
    $finish;
  end

  initial begin
    rst = 1'b1;
    apply_stimulus(NOP, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check_output("reset_out", 48'(dut_vec), 48'h0);
    check_output("reset_stall", 48'(bus.ex_stall), 48'(1'b1));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    $display("[TB] single-cycle opcodes");
    single(ADD,  16'h7FFF, 16'h0001, 16'h0, 16'h0, 3'd1, 1'b0, 1'b0, 1'b1,
           pack(ADD, 16'h8000, 16'h0, 3'd1, 1'b0, 1'b0, 1'b1), "add");
    single(SUB,  16'h0005, 16'h0007, 16'h0, 16'h0, 3'd2, 1'b0, 1'b0, 1'b1,
           pack(SUB, 16'hFFFE, 16'h0, 3'd2, 1'b0, 1'b0, 1'b1), "sub");
    single(AND,  16'hF0F0, 16'h3C3C, 16'h0, 16'h0, 3'd3, 1'b0, 1'b0, 1'b1,
           pack(AND, 16'h3030, 16'h0, 3'd3, 1'b0, 1'b0, 1'b1), "and");
    single(OR,   16'hF0F0, 16'h0F01, 16'h0, 16'h0, 3'd4, 1'b0, 1'b0, 1'b1,
           pack(OR, 16'hFFF1, 16'h0, 3'd4, 1'b0, 1'b0, 1'b1), "or");
    single(XOR,  16'hFFFF, 16'h1234, 16'h0, 16'h0, 3'd5, 1'b0, 1'b0, 1'b1,
           pack(XOR, 16'hEDCB, 16'h0, 3'd5, 1'b0, 1'b0, 1'b1), "xor");
    single(SLL,  16'h0001, 16'h0013, 16'h0, 16'h0, 3'd6, 1'b0, 1'b0, 1'b1,
           pack(SLL, 16'h0008, 16'h0, 3'd6, 1'b0, 1'b0, 1'b1), "sll");
    single(SRL,  16'h8000, 16'h0004, 16'h0, 16'h0, 3'd7, 1'b0, 1'b0, 1'b1,
           pack(SRL, 16'h0800, 16'h0, 3'd7, 1'b0, 1'b0, 1'b1), "srl");
    single(SRA,  16'h8000, 16'h0004, 16'h0, 16'h0, 3'd1, 1'b0, 1'b0, 1'b1,
           pack(SRA, 16'hF800, 16'h0, 3'd1, 1'b0, 1'b0, 1'b1), "sra");
    single(ADDI, 16'h0010, 16'h0, 16'hFFFF, 16'h0, 3'd2, 1'b0, 1'b0, 1'b1,
           pack(ADDI, 16'h000F, 16'h0, 3'd2, 1'b0, 1'b0, 1'b1), "addi");
    single(LD,   16'h1000, 16'h0, 16'h0020, 16'h0, 3'd3, 1'b0, 1'b1, 1'b1,
           pack(LD, 16'h1020, 16'h0, 3'd3, 1'b0, 1'b1, 1'b1), "ld");
    single(4'd14, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 3'd5, 1'b1, 1'b1, 1'b1,
           pack(NOP, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0), "op14");
    single(4'd15, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 3'd5, 1'b1, 1'b1, 1'b1,
           pack(NOP, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0), "op15");

    $display("[TB] store then downstream stall");
    single(ST, 16'h0010, 16'h0, 16'h0004, 16'hBEEF, 3'd0, 1'b1, 1'b0, 1'b0,
           pack(ST, 16'h0014, 16'hBEEF, 3'd0, 1'b1, 1'b0, 1'b0), "st");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      apply_stimulus(ADD, 16'h0100, 16'h0002, 16'h0003, 16'h0, 16'h0, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0);
      #1;
      check_output("st_hold_stall", 48'(bus.ex_stall), 48'(1'b1));
      check_output("st_hold_mw", 48'(bus.ex_mem_write_en), 48'(1'b1));
    end
    single(ADD, 16'h0002, 16'h0003, 16'h0, 16'h0, 3'd4, 1'b0, 1'b0, 1'b1,
           pack(ADD, 16'h0005, 16'h0, 3'd4, 1'b0, 1'b0, 1'b1), "add_after_stall");

    $display("[TB] multiply, mem_ready held high");
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      if (k == 0)
        apply_stimulus(MUL, 16'h0100, 16'h0123, 16'h0045, 16'h0, 16'h0, 3'd5, 1'b0, 1'b0, 1'b1, 1'b1);
      #1;
      check_output("mul_stall", 48'(bus.ex_stall), 48'(1'b1));
      exp_q.push_back('0);
    end
    @(negedge clk);
    #1;
    check_output("mul_done_stall", 48'(bus.ex_stall), 48'(1'b0));
    exp_q.push_back(pack(MUL, 16'h4E6F, 16'h0, 3'd5, 1'b0, 1'b0, 1'b1));

    $display("[TB] multiply with mem_ready gaps and held DONE");
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      if (k == 0)
        apply_stimulus(MUL, 16'h0100, 16'h0003, 16'hFFFF, 16'h0, 16'h0, 3'd3, 1'b0, 1'b1, 1'b1, 1'b1);
      else
        bus.mem_ready = !(k >= 5 && k <= 8);
      #1;
      check_output("mul2_stall", 48'(bus.ex_stall), 48'(1'b1));
      if (bus.mem_ready) exp_q.push_back('0);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.mem_ready = 1'b0;
      #1;
      check_output("mul2_done_hold_stall", 48'(bus.ex_stall), 48'(1'b1));
    end
    @(negedge clk);
    bus.mem_ready = 1'b1;
    #1;
    check_output("mul2_release_stall", 48'(bus.ex_stall), 48'(1'b0));
    exp_q.push_back(pack(MUL, 16'hFFFD, 16'h0, 3'd3, 1'b0, 1'b1, 1'b1));

    $display("[TB] branch on zero");
    @(negedge clk);
    apply_stimulus(BZ, 16'hFFFE, 16'h0000, 16'h0, 16'h0004, 16'h1111, 3'd2, 1'b1, 1'b1, 1'b1, 1'b1);
    #1;
    check_output("bz_taken", 48'(bus.ex_branch_taken), 48'(1'b1));
    check_output("bz_target", 48'(bus.ex_branch_target), 48'h0002);
    exp_q.push_back(pack(BZ, 16'h0, 16'h1111, 3'd2, 1'b0, 1'b1, 1'b0));
    @(negedge clk);
    apply_stimulus(BZ, 16'h1000, 16'h0001, 16'h0, 16'hFFF0, 16'h2222, 3'd6, 1'b1, 1'b0, 1'b1, 1'b1);
    #1;
    check_output("bz_nz_taken", 48'(bus.ex_branch_taken), 48'(1'b0));
    check_output("bz_nz_target", 48'(bus.ex_branch_target), 48'h0FF0);
    exp_q.push_back(pack(BZ, 16'h0, 16'h2222, 3'd6, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    apply_stimulus(BZ, 16'h0200, 16'h0000, 16'h0, 16'h0010, 16'h0, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    check_output("bz_stalled_taken", 48'(bus.ex_branch_taken), 48'(1'b0));

    $display("[TB] asynchronous reset");
    single(ADD, 16'h0001, 16'h0002, 16'h0, 16'h0, 3'd1, 1'b0, 1'b0, 1'b1,
           pack(ADD, 16'h0003, 16'h0, 3'd1, 1'b0, 1'b0, 1'b1), "add_pre_rst");
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_output("async_rst_out", 48'(dut_vec), 48'h0);
    @(negedge clk);
    rst = 1'b0;
    bus.mem_ready = 1'b0;

    $display("[TB] reset aborts multiply");
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0)
        apply_stimulus(MUL, 16'h0100, 16'h0123, 16'h0045, 16'h0, 16'h0, 3'd4, 1'b0, 1'b0, 1'b1, 1'b1);
      exp_q.push_back('0);
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    apply_stimulus(ADD, 16'h0100, 16'h0003, 16'h0004, 16'h0, 16'h0, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1);
    #1;
    check_output("abort_rst_out", 48'(dut_vec), 48'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_output("abort_idle_stall", 48'(bus.ex_stall), 48'(1'b0));
    exp_q.push_back(pack(ADD, 16'h0007, 16'h0, 3'd2, 1'b0, 1'b0, 1'b1));
    for (int k = 0; k < 20; k++)
      single(NOP, 16'h0, 16'h0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0,
             pack(NOP, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0), "post_abort_nop");

    @(negedge clk);
    bus.mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_output("sb_drain", 48'(exp_q.size()), 48'h0);
    print_summary();
    $finish;
  end

endmodule
